// File: rtl/acp_chan_regs.sv
`default_nettype none
// ============================================================================
//  Module   : acp_chan_regs
//  Purpose  : Channel-control register block on the receiving side of the ACP.
//             16-bit writes land in per-channel shadow registers. A
//             synchronized note_clk rising edge ("tick") commits dirty shadows
//             to the live outputs. An optional per-channel length counter
//             disables a channel after N ticks.
//  Ports    : clk50mhz_i       - system clock
//             rst_n_i          - synchronous active-low reset
//             note_clk_i       - asynchronous note clock, synchronized here
//             wr_valid_i/wr_ready_o, wr_addr_i, wr_data_i - write channel
//             rd_addr_i / rd_data_o - registered read port (1-cycle latency)
//             ch_note_o, ch_en_o, ch_fx_sel_o, ch_fx_optA_o, ch_fx_optB_o
//                              - live per-channel controls, ch0 in the LSBs
//             commit_strobe_o  - one-cycle pulse after any channel commit
//  Address  : {ch[1:0], reg_sel}; reg_sel 0 = CTRL, 1 = LEN
//  Revision : 1.0 - initial release
// ============================================================================
module acp_chan_regs #(
  parameter int NCH         = 4,  // address map has a 2-bit channel index
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic               clk50mhz_i,
  input  logic               rst_n_i,
  input  logic               note_clk_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [2:0]         wr_addr_i,
  input  logic [15:0]        wr_data_i,
  input  logic [2:0]         rd_addr_i,
  output logic [15:0]        rd_data_o,
  output logic [6*NCH-1:0]   ch_note_o,
  output logic [NCH-1:0]     ch_en_o,
  output logic [2*NCH-1:0]   ch_fx_sel_o,
  output logic [2*NCH-1:0]   ch_fx_optA_o,
  output logic [2*NCH-1:0]   ch_fx_optB_o,
  output logic               commit_strobe_o
);

  // note_clk synchronizer plus one history flop for rising-edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick;

  // CTRL shadow keeps bits [12:0]; LEN shadow keeps {length_en, length}
  logic [12:0]    ctrl_q [NCH];
  logic [12:0]    ctrl_d [NCH];
  logic [8:0]     len_q  [NCH];
  logic [8:0]     len_d  [NCH];
  logic [7:0]     cnt_q  [NCH];
  logic [7:0]     cnt_d  [NCH];
  logic [5:0]     note_q [NCH];
  logic [5:0]     note_d [NCH];
  logic [1:0]     fxs_q  [NCH];
  logic [1:0]     fxs_d  [NCH];
  logic [1:0]     fxa_q  [NCH];
  logic [1:0]     fxa_d  [NCH];
  logic [1:0]     fxb_q  [NCH];
  logic [1:0]     fxb_d  [NCH];
  logic [NCH-1:0] dirty_q, dirty_d;
  logic [NCH-1:0] en_q, en_d;
  logic           commit_q, commit_d;
  logic [15:0]    rd_q, rd_d;

  logic           wr_fire;
  logic [1:0]     wr_ch;
  logic [1:0]     rd_ch;
  logic [2:0]     unused_wr_bits;

  assign unused_wr_bits = wr_data_i[15:13];

  always_comb begin
    tick       = sync_q[SYNC_STAGES-1] & ~hist_q;
    // Writes are refused during the tick cycle so commit and update never collide
    wr_ready_o = rst_n_i & ~tick;
    wr_fire    = wr_valid_i & wr_ready_o;
    wr_ch      = wr_addr_i[2:1];
    rd_ch      = rd_addr_i[2:1];
  end

  // Read mux samples pre-edge state, so a same-cycle write reads the old value
  always_comb begin
    if (rd_addr_i[0]) begin
      rd_d = {en_q[rd_ch], 6'b0, len_q[rd_ch]};
    end else begin
      rd_d = {3'b0, ctrl_q[rd_ch]};
    end
  end

  always_comb begin
    commit_d = tick & (|dirty_q);
    dirty_d  = dirty_q;
    en_d     = en_q;
    for (int c = 0; c < NCH; c++) begin
      ctrl_d[c] = ctrl_q[c];
      len_d[c]  = len_q[c];
      cnt_d[c]  = cnt_q[c];
      note_d[c] = note_q[c];
      fxs_d[c]  = fxs_q[c];
      fxa_d[c]  = fxa_q[c];
      fxb_d[c]  = fxb_q[c];

      if (tick) begin
        if (dirty_q[c]) begin
          note_d[c]  = ctrl_q[c][5:0];
          fxs_d[c]   = ctrl_q[c][7:6];
          fxa_d[c]   = ctrl_q[c][9:8];
          fxb_d[c]   = ctrl_q[c][11:10];
          dirty_d[c] = 1'b0;
          if (len_q[c][8]) begin
            // A zero length means the channel never turns on
            cnt_d[c] = len_q[c][7:0];
            en_d[c]  = ctrl_q[c][12] & (len_q[c][7:0] != 8'd0);
          end else begin
            cnt_d[c] = 8'd0;
            en_d[c]  = ctrl_q[c][12];
          end
        end else if (len_q[c][8] && en_q[c] && (cnt_q[c] != 8'd0)) begin
          cnt_d[c] = cnt_q[c] - 8'd1;
          if (cnt_q[c] == 8'd1) begin
            en_d[c] = 1'b0;
          end
        end
      end

      if (wr_fire && (wr_ch == 2'(c))) begin
        if (wr_addr_i[0]) begin
          len_d[c] = wr_data_i[8:0];
        end else begin
          ctrl_d[c] = wr_data_i[12:0];
        end
        dirty_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50mhz_i) begin
    if (!rst_n_i) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      dirty_q  <= '0;
      en_q     <= '0;
      commit_q <= 1'b0;
      rd_q     <= '0;
      for (int c = 0; c < NCH; c++) begin
        ctrl_q[c] <= '0;
        len_q[c]  <= '0;
        cnt_q[c]  <= '0;
        note_q[c] <= '0;
        fxs_q[c]  <= '0;
        fxa_q[c]  <= '0;
        fxb_q[c]  <= '0;
      end
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], note_clk_i};
      hist_q   <= sync_q[SYNC_STAGES-1];
      dirty_q  <= dirty_d;
      en_q     <= en_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      note_q   <= note_d;
      fxs_q    <= fxs_d;
      fxa_q    <= fxa_d;
      fxb_q    <= fxb_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign ch_note_o[6*g +: 6]    = note_q[g];
    assign ch_fx_sel_o[2*g +: 2]  = fxs_q[g];
    assign ch_fx_optA_o[2*g +: 2] = fxa_q[g];
    assign ch_fx_optB_o[2*g +: 2] = fxb_q[g];
  end

  assign ch_en_o         = en_q;
  assign commit_strobe_o = commit_q;
  assign rd_data_o       = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_acp_chan_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acp_chan_regs
//  Purpose  : Self-checking bench for acp_chan_regs. The driver pushes the
//             expected per-cycle response of a behavioural model into a
//             queue; a negedge monitor pops and compares against the DUT.
//             Directed scenarios are followed by a randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acp_chan_regs;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        note_clk = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [23:0] ch_note;
  logic [3:0]  ch_en;
  logic [7:0]  ch_fx_sel, ch_fx_optA, ch_fx_optB;
  logic        commit_strobe;

  acp_chan_regs #(.NCH(4), .SYNC_STAGES(S)) dut (
    .clk50mhz_i     (clk),
    .rst_n_i        (rst_n),
    .note_clk_i     (note_clk),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .ch_note_o      (ch_note),
    .ch_en_o        (ch_en),
    .ch_fx_sel_o    (ch_fx_sel),
    .ch_fx_optA_o   (ch_fx_optA),
    .ch_fx_optB_o   (ch_fx_optB),
    .commit_strobe_o(commit_strobe)
  );

  always #5 clk = ~clk;

  // ---------------- counters and check helper ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Shadow registers as written by software, the channel state as seen on the
  // outputs, and a delay line of note_clk samples standing in for the
  // synchronizer: a rise becomes visible S-1 edges after it was sampled.
  int unsigned m_ctrl[4], m_len[4], m_left[4];
  int unsigned m_note[4], m_fs[4], m_fa[4], m_fb[4];
  bit          m_dirty[4], m_en[4];
  bit          m_commit;
  int unsigned m_rd;
  bit          hist[$];

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_ctrl[c] = 0; m_len[c] = 0; m_left[c] = 0;
      m_note[c] = 0; m_fs[c] = 0; m_fa[c] = 0; m_fb[c] = 0;
      m_dirty[c] = 0; m_en[c] = 0;
    end
    m_commit = 0;
    m_rd = 0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(1'b0);
  endtask

  function automatic bit model_tick();
    return hist[S-1] && !hist[S];
  endfunction

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input bit r, input bit nc, input bit v, input logic [2:0] a,
                            input logic [15:0] d, input logic [2:0] ra, output bit acc);
    bit tk;
    int ch, rch;
    acc = 0;
    if (!r) begin
      model_reset();
      return;
    end
    tk  = model_tick();
    rch = int'(ra[2:1]);
    m_rd = ra[0] ? ((m_en[rch] ? 32'h8000 : 0) | m_len[rch]) : m_ctrl[rch];
    m_commit = 0;
    if (tk) begin
      for (int c = 0; c < 4; c++) begin
        if (m_dirty[c]) begin
          m_commit = 1;
          m_dirty[c] = 0;
          m_note[c] = m_ctrl[c] % 64;
          m_fs[c]   = (m_ctrl[c] / 64) % 4;
          m_fa[c]   = (m_ctrl[c] / 256) % 4;
          m_fb[c]   = (m_ctrl[c] / 1024) % 4;
          if (m_len[c] >= 256) begin
            m_left[c] = m_len[c] % 256;
            m_en[c]   = (m_ctrl[c] >= 4096) && (m_left[c] > 0);
          end else begin
            m_left[c] = 0;
            m_en[c]   = (m_ctrl[c] >= 4096);
          end
        end else if (m_len[c] >= 256 && m_en[c] && m_left[c] > 0) begin
          m_left[c]--;
          if (m_left[c] == 0) m_en[c] = 0;
        end
      end
    end
    if (v && !tk) begin
      ch = int'(a[2:1]);
      if (a[0]) m_len[ch] = d & 16'h01FF;
      else      m_ctrl[ch] = d & 16'h1FFF;
      m_dirty[ch] = 1;
      acc = 1;
    end
    hist.push_front(nc);
    void'(hist.pop_back());
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        rdy;
    logic [15:0] rd;
    logic [23:0] note;
    logic [3:0]  en;
    logic [7:0]  fs, fa, fb;
    logic        cs;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      mon_e = expq.pop_front();
      chk("wr_ready",      {31'b0, wr_ready},      {31'b0, mon_e.rdy});
      chk("rd_data",       {16'b0, rd_data},       {16'b0, mon_e.rd});
      chk("ch_note",       {8'b0, ch_note},        {8'b0, mon_e.note});
      chk("ch_en",         {28'b0, ch_en},         {28'b0, mon_e.en});
      chk("ch_fx_sel",     {24'b0, ch_fx_sel},     {24'b0, mon_e.fs});
      chk("ch_fx_optA",    {24'b0, ch_fx_optA},    {24'b0, mon_e.fa});
      chk("ch_fx_optB",    {24'b0, ch_fx_optB},    {24'b0, mon_e.fb});
      chk("commit_strobe", {31'b0, commit_strobe}, {31'b0, mon_e.cs});
    end
  end

  // ---------------- driver ----------------
  logic        n_rst = 1'b0, n_nclk = 1'b0, n_valid = 1'b0;
  logic [2:0]  n_addr = '0, n_rd = '0;
  logic [15:0] n_data = '0;
  bit          last_acc;

  // One clock cycle: drive inputs after the edge, push the response expected
  // at the following negedge, then advance the model over the next edge.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = n_rst; note_clk = n_nclk; wr_valid = n_valid;
    wr_addr = n_addr; wr_data = n_data; rd_addr = n_rd;
    e.rdy  = n_rst && !model_tick();
    e.rd   = 16'(m_rd);
    e.note = {6'(m_note[3]), 6'(m_note[2]), 6'(m_note[1]), 6'(m_note[0])};
    e.en   = {m_en[3], m_en[2], m_en[1], m_en[0]};
    e.fs   = {2'(m_fs[3]), 2'(m_fs[2]), 2'(m_fs[1]), 2'(m_fs[0])};
    e.fa   = {2'(m_fa[3]), 2'(m_fa[2]), 2'(m_fa[1]), 2'(m_fa[0])};
    e.fb   = {2'(m_fb[3]), 2'(m_fb[2]), 2'(m_fb[1]), 2'(m_fb[0])};
    e.cs   = m_commit;
    expq.push_back(e);
    model_edge(n_rst, n_nclk, n_valid, n_addr, n_data, n_rd, last_acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d, output int stalls);
    stalls = 0;
    n_valid = 1; n_addr = a; n_data = d;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (last_acc) break;
      stalls++;
    end
    if (!last_acc) chk("write_accept_timeout", 32'd0, 32'd1);
    n_valid = 0;
  endtask

  task automatic note_pulse();
    n_nclk = 1; idle(4);
    n_nclk = 0; idle(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    model_reset();

    // Reset held with note_clk toggling
    n_rst = 0;
    for (int i = 0; i < 3; i++) begin n_nclk = ~n_nclk; cyc(); end
    @(negedge clk);
    chk("reset_wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("reset_ch_en",    {28'b0, ch_en},    32'd0);
    n_nclk = 0; n_rst = 1;
    idle(4);
    for (int a = 0; a < 8; a++) begin n_rd = 3'(a); cyc(); end
    idle(1);
    @(negedge clk);
    chk("post_reset_wr_ready", {31'b0, wr_ready}, 32'd1);

    // Basic commit on ch0 with exact latency
    do_write(3'd0, 16'h1029, st);
    idle(2);
    n_nclk = 1;
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("pre_commit_ch_en0",   {31'b0, ch_en[0]},  32'd0);
    chk("tick_cycle_wr_ready", {31'b0, wr_ready},  32'd0);
    cyc();
    @(negedge clk);
    chk("commit_note0",  {26'b0, ch_note[5:0]},   32'd41);
    chk("commit_en0",    {31'b0, ch_en[0]},       32'd1);
    chk("commit_strobe", {31'b0, commit_strobe},  32'd1);
    cyc();
    @(negedge clk);
    chk("strobe_one_cycle", {31'b0, commit_strobe}, 32'd0);
    n_nclk = 0; idle(4);

    // Length counter on ch2: len 3
    do_write(3'd5, 16'h0103, st);
    do_write(3'd4, 16'h1007, st);
    n_rd = 3'd5;
    note_pulse();
    @(negedge clk);
    chk("len_commit_en2",  {31'b0, ch_en[2]}, 32'd1);
    chk("len_rd_live_bit", {16'b0, rd_data},  32'h8103);
    note_pulse();
    @(negedge clk);
    chk("len_tick1_en2", {31'b0, ch_en[2]}, 32'd1);
    note_pulse();
    @(negedge clk);
    chk("len_tick2_en2", {31'b0, ch_en[2]}, 32'd1);
    note_pulse();
    @(negedge clk);
    chk("len_tick3_en2",  {31'b0, ch_en[2]},      32'd0);
    chk("len_note2_held", {26'b0, ch_note[17:12]}, 32'd7);
    chk("len_rd_cleared", {16'b0, rd_data},        32'h0103);

    // Collision with tick, then last-write-wins on ch1
    n_nclk = 1;
    cyc(); cyc();
    do_write(3'd2, 16'h100D, st);
    chk("collision_stalls", st, 32'd1);
    do_write(3'd2, 16'h1019, st);
    n_nclk = 0; idle(4);
    @(negedge clk);
    chk("collision_not_yet", {26'b0, ch_note[11:6]}, 32'd0);
    note_pulse();
    @(negedge clk);
    chk("last_write_wins", {26'b0, ch_note[11:6]}, 32'd25);

    // Edge values on ch3
    do_write(3'd7, 16'h0100, st);
    do_write(3'd6, 16'hFFFF, st);
    n_rd = 3'd6; idle(2);
    @(negedge clk);
    chk("ctrl_readback_mask", {16'b0, rd_data}, 32'h1FFF);
    note_pulse();
    @(negedge clk);
    chk("zero_len_en3", {31'b0, ch_en[3]},        32'd0);
    chk("ffff_note3",   {26'b0, ch_note[23:18]},  32'h3F);
    n_rd = 3'd7; idle(2);
    @(negedge clk);
    chk("len_readback", {16'b0, rd_data}, 32'h0100);

    // Mid-operation reset discards the pending commit
    do_write(3'd6, 16'h1015, st);
    n_nclk = 1; cyc();
    n_rst = 0; cyc();
    n_rst = 1; idle(6);
    n_nclk = 0; idle(4);
    @(negedge clk);
    chk("midreset_ch_en",   {28'b0, ch_en},   32'd0);
    chk("midreset_ch_note", {8'b0, ch_note},  32'd0);

    // Randomized phase, writes held until accepted
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) n_nclk = ~n_nclk;
      n_rd  = 3'($urandom);
      n_rst = ($urandom_range(0, 149) != 0);
      if (!n_valid && $urandom_range(0, 2) == 0) begin
        n_valid = 1;
        n_addr  = 3'($urandom);
        n_data  = 16'($urandom);
        if (n_addr[0]) n_data[7:0] = 8'($urandom_range(0, 3));
      end
      cyc();
      if (last_acc) n_valid = 0;
    end
    n_valid = 0;
    idle(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acp_chan_regs.md
Name: acp_chan_regs

Overview:
Receiving end of the channel-control path. Accepts 16-bit register writes from the ACP over a valid/ready bus and holds them in per-channel shadow registers. On each note_clk rising edge it commits dirty channels to the live note_in / channel_en / fx_sel / fx_optA / fx_optB outputs that drive the four sound channels. It also runs a per-channel length counter that auto-disables a channel after N note clocks. Replaces hardwired state-machine note sequencing in the top level.

Parameters:
NCH, 4, number of channels (fixed 4; address map assumes 2-bit channel index)
SYNC_STAGES, 2, synchronizer flops on note_clk before edge detect

Ports:
clk50mhz  in  1  system clock, 50 MHz
rst_n  in  1  reset, synchronous, active-low
note_clk  in  1  note timing clock (1/256-note half period); treated as async, synchronized internally
wr_valid  in  1  write request
wr_ready  out  1  block accepts write this cycle
wr_addr  in  3  {ch[1:0], reg_sel}
wr_data  in  16  write data
rd_addr  in  3  {ch[1:0], reg_sel}
rd_data  out  16  read data, 1-cycle latency
ch_note  out  24  4 x 6-bit note_in, ch0 in [5:0]
ch_en  out  4  live channel enables
ch_fx_sel  out  8  4 x 2-bit fx_sel
ch_fx_optA  out  8  4 x 2-bit fx_optA
ch_fx_optB  out  8  4 x 2-bit fx_optB
commit_strobe  out  1  1-cycle pulse when at least one channel committed

Behaviour:
- Register map, per channel:
  - reg_sel=0 (CTRL): [5:0] note, [7:6] fx_sel, [9:8] fx_optA, [11:10] fx_optB, [12] enable, [15:13] reserved (ignored on write, read 0).
  - reg_sel=1 (LEN): [7:0] length in note_clk ticks, [8] length_en, [14:9] reserved (read 0), [15] read-only live ch_en of that channel.
- Reset (rst_n=0 at clk edge): all shadows, dirty bits, length counters, outputs, rd_data, commit_strobe and sync flops = 0. wr_ready=0 while rst_n=0.
- Sync: note_clk passes SYNC_STAGES flops plus one history flop. tick = synced & ~history. A note_clk rise sampled at edge k produces tick high in the cycle after edge k+SYNC_STAGES-1. Outputs update at the following edge.
- Write handshake: transfer occurs when wr_valid & wr_ready at the clk edge. wr_ready = ~tick (high after reset except during tick cycles). A write stalled by tick stays pending on the master side; wr_data and wr_addr must be held.
- An accepted write updates the addressed shadow and sets dirty[ch]. Multiple writes before a tick: last value wins.
- On tick, per channel:
  - If dirty: copy CTRL shadow to outputs and clear dirty. If length_en=1, load the counter with length; a length of 0 forces ch_en=0 regardless of the enable bit. If length_en=0, the counter is idle and ch_en equals the enable bit.
  - If not dirty, length_en active, ch_en=1 and counter>0: decrement. On the 1->0 transition, ch_en clears at the same edge. Note/fx outputs are held.
  - The commit tick never decrements.
- commit_strobe = 1 for exactly the cycle after any dirty commit.
- Read: rd_data registered from rd_addr every cycle; returns shadow values, not live values (except LEN[15]). A read in the same cycle as a write to the same address returns the pre-write value.
- rst_n deasserted mid-operation: pending dirty state and counters are discarded; no commit occurs until a new write and a new tick.
- Counter width is 8 bits; no wrap. The counter stops at 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with note_clk toggling -> all outputs 0, wr_ready=0; after release wr_ready=1, rd_data=0 for every address.
- Basic commit: write ch0 CTRL=0x1029 (note 41, en=1), then raise note_clk -> ch_note[5:0]=41 and ch_en[0]=1 exactly SYNC_STAGES+1 edges after first sampling, with a one-cycle commit_strobe; no output change before the tick.
- Length: ch2 LEN=0x0103 (len 3, en), CTRL en=1 -> ch_en[2]=1 at commit, stays 1 for 2 further ticks, clears on the 3rd tick after commit; notes unchanged.
- Collision: wr_valid held through a tick cycle -> wr_ready=0 for that cycle, write lands on the next cycle, committed only on the following tick; two writes to ch1 CTRL (note 13 then note 25) -> output 25.
- Edge values: LEN=0x0100 with en=1 -> ch_en stays 0 after commit; write CTRL=0xFFFF -> readback 0x1FFF; LEN readback bit15 tracks live ch_en.
- Mid-op reset: write ch3, assert rst_n=0 for 1 cycle before the tick -> no commit_strobe, outputs remain 0.
